// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, FSM encoding and stage indicator codes for the ALU board top
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOTA = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ROL  = 4'd8,
    OP_ROR  = 4'd9,
    OP_INC  = 4'd10,
    OP_DEC  = 4'd11,
    OP_LTU  = 4'd12,
    OP_EQ   = 4'd13,
    OP_MUL  = 4'd14,
    OP_PASB = 4'd15
  } op_e;

  // FSM state encoding
  localparam logic [2:0] ST_LOAD_A  = 3'd0;
  localparam logic [2:0] ST_LOAD_B  = 3'd1;
  localparam logic [2:0] ST_LOAD_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SHOW    = 3'd4;

  // Stage indicator patterns
  localparam logic [2:0] SLED_LOAD_A  = 3'b001;
  localparam logic [2:0] SLED_LOAD_B  = 3'b010;
  localparam logic [2:0] SLED_LOAD_OP = 3'b100;
  localparam logic [2:0] SLED_EXEC    = 3'b000;
  localparam logic [2:0] SLED_SHOW    = 3'b111;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
  } flags_t;

  function automatic logic [2:0] state_led(input logic [2:0] st);
    case (st)
      ST_LOAD_A:  state_led = SLED_LOAD_A;
      ST_LOAD_B:  state_led = SLED_LOAD_B;
      ST_LOAD_OP: state_led = SLED_LOAD_OP;
      ST_SHOW:    state_led = SLED_SHOW;
      default:    state_led = SLED_EXEC;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - switch, button and LED bundle of the ALU board top
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] SW;
  logic [1:0]       BTN;
  logic [WIDTH-1:0] LED;
  logic [2:0]       STATE_LED;
  logic             CARRY_LED;
  logic             ZERO_LED;
  logic             OVF_LED;

  modport master (
    output SW, BTN,
    input  LED, STATE_LED, CARRY_LED, ZERO_LED, OVF_LED
  );

  modport slave (
    input  SW, BTN,
    output LED, STATE_LED, CARRY_LED, ZERO_LED, OVF_LED
  );
endinterface

// File: rtl/alu_seq_btn_conditioner.sv
// rtl/alu_seq_btn_conditioner.sv - synchroniser, debouncer and press-pulse generator for one button
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_prev_q;
  logic [CW-1:0] cnt_q;

  // Two-flop synchroniser for the raw button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level once it has differed from the current one for DEBOUNCE_CYCLES samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
      cnt_q   <= '0;
      level_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Delayed level for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev_q <= 1'b0;
    else     level_prev_q <= level_q;
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/alu_seq_top.sv
// rtl/alu_seq_top.sv - serial-entry ALU board top with debounced buttons and registered LEDs
module alu_seq_top #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);
  import alu_seq_pkg::*;

  logic [1:0]         btn_level;
  logic               enter_press, clear_press;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  op_e                op_q, op_d;
  flags_t             flags_q, flags_d;
  logic [WIDTH-1:0]   led_q, led_d;
  logic [2:0]         sled_q, sled_d;

  logic               use_sub, is_arith;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     arith;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flags;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_enter (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.BTN[0]),
    .level_o (btn_level[0]),
    .press_o (enter_press)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
    .clk     (clk),
    .rst     (rst),
    .raw_i   (bus.BTN[1]),
    .level_o (btn_level[1]),
    .press_o (clear_press)
  );

  // ALU: one shared add/sub for ADD/SUB/INC/DEC, full-width product for MUL
  always_comb begin
    use_sub  = (op_q == OP_SUB) || (op_q == OP_DEC);
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_INC) || (op_q == OP_DEC);
    addend   = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? b_q : WIDTH'(1);
    arith    = use_sub ? ({1'b0, a_q} - {1'b0, addend}) : ({1'b0, a_q} + {1'b0, addend});
    prod     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    alu_res         = '0;
    alu_flags.carry = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
        alu_res         = arith[WIDTH-1:0];
        alu_flags.carry = arith[WIDTH];
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_NOTA: alu_res = ~a_q;
      OP_SHL: begin
        alu_res         = {a_q[WIDTH-2:0], 1'b0};
        alu_flags.carry = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res         = {1'b0, a_q[WIDTH-1:1]};
        alu_flags.carry = a_q[0];
      end
      OP_ROL:  alu_res = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OP_ROR:  alu_res = {a_q[0], a_q[WIDTH-1:1]};
      OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, a_q < b_q};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a_q == b_q};
      OP_MUL: begin
        alu_res         = prod[WIDTH-1:0];
        alu_flags.carry = |prod[2*WIDTH-1:WIDTH];
      end
      default: alu_res = b_q;
    endcase
    // Signed overflow: operand signs (after subtraction flips the addend) agree but result sign differs
    alu_flags.ovf  = is_arith &&
                     (use_sub ? (a_q[WIDTH-1] != addend[WIDTH-1]) : (a_q[WIDTH-1] == addend[WIDTH-1])) &&
                     (arith[WIDTH-1] != a_q[WIDTH-1]);
    alu_flags.zero = (alu_res == '0);
  end

  // Entry FSM and operand/result register next state; CLEAR overrides ENTER
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    if (clear_press) begin
      state_d = ST_LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = OP_ADD;
      res_d   = '0;
      flags_d = '0;
    end else begin
      case (state_q)
        ST_LOAD_A: if (enter_press) begin
          a_d     = bus.SW;
          state_d = ST_LOAD_B;
        end
        ST_LOAD_B: if (enter_press) begin
          b_d     = bus.SW;
          state_d = ST_LOAD_OP;
        end
        ST_LOAD_OP: if (enter_press) begin
          op_d    = op_e'(bus.SW[3:0]);
          state_d = ST_EXEC;
        end
        ST_EXEC: begin
          res_d   = alu_res;
          flags_d = alu_flags;
          state_d = ST_SHOW;
        end
        ST_SHOW: if (enter_press) begin
          a_d     = res_q;
          state_d = ST_LOAD_B;
        end
        default: state_d = ST_LOAD_A;
      endcase
    end
    led_d  = (state_d == ST_SHOW) ? res_d : bus.SW;
    sled_d = state_led(state_d);
  end

  // State, operand, result and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flags_q <= '0;
      led_q   <= '0;
      sled_q  <= SLED_LOAD_A;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      led_q   <= led_d;
      sled_q  <= sled_d;
    end
  end

  assign bus.LED       = led_q;
  assign bus.STATE_LED = sled_q;
  assign bus.CARRY_LED = flags_q.carry;
  assign bus.ZERO_LED  = flags_q.zero;
  assign bus.OVF_LED   = flags_q.ovf;

endmodule

// File: tb/tb_alu_seq_top.sv
// tb/tb_alu_seq_top.sv - self-checking bench for alu_seq_top
module tb_alu_seq_top;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   last_res;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq_top #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  task automatic model(input int a, input int b, input int op,
                       output int r, output bit c, output bit z, output bit v);
    int m, h, sa, sb, s, p;
    m = 1 << W;
    h = m / 2;
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r = 0; c = 0; v = 0; s = 0;
    case (op)
      0:  begin r = (a + b) % m; c = (a + b) >= m; s = sa + sb; v = (s >= h) || (s < -h); end
      1:  begin r = (a - b + m) % m; c = a < b; s = sa - sb; v = (s >= h) || (s < -h); end
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = m - 1 - a;
      6:  begin r = (a * 2) % m; c = a >= h; end
      7:  begin r = a / 2; c = (a % 2) == 1; end
      8:  r = (a * 2) % m + a / h;
      9:  r = a / 2 + (a % 2) * h;
      10: begin r = (a + 1) % m; c = (a + 1) >= m; s = sa + 1; v = (s >= h) || (s < -h); end
      11: begin r = (a - 1 + m) % m; c = a == 0; s = sa - 1; v = (s >= h) || (s < -h); end
      12: r = (a < b) ? 1 : 0;
      13: r = (a == b) ? 1 : 0;
      14: begin p = a * b; r = p % m; c = p >= m; end
      default: r = b;
    endcase
    z = (r == 0);
  endtask

  task automatic release_btns();
    bus.BTN = 2'b00;
    repeat (12) @(negedge clk);
  endtask

  // Clean press: FSM moves on the (D+3)th edge counted from 0, then must not move again
  task automatic press(input int b, input logic [2:0] exp_state, input string tag);
    bus.BTN[b] = 1'b1;
    repeat (D + 4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_state"}, bus.STATE_LED, exp_state);
    repeat (3) @(negedge clk);
    chk({tag, "_hold"}, bus.STATE_LED, exp_state);
    release_btns();
  endtask

  // Opcode entry: one cycle of EXEC, then result and flags together in SHOW
  task automatic press_op(input int r, input bit c, input bit z, input bit v, input string tag);
    bus.BTN[0] = 1'b1;
    repeat (D + 4) @(posedge clk);
    @(negedge clk);
    chk({tag, "_exec"}, bus.STATE_LED, 3'b000);
    @(negedge clk);
    chk({tag, "_show"}, bus.STATE_LED, 3'b111);
    chk({tag, "_res"}, bus.LED, r);
    chk({tag, "_c"}, bus.CARRY_LED, c);
    chk({tag, "_z"}, bus.ZERO_LED, z);
    chk({tag, "_v"}, bus.OVF_LED, v);
    release_btns();
    bus.SW = W'($urandom);
    @(negedge clk);
    chk({tag, "_res_held"}, bus.LED, r);
  endtask

  task automatic enter_op(input int a, input int b, input int op, input string tag);
    int r; bit c, z, v;
    model(a, b, op, r, c, z, v);
    bus.SW = W'(b);
    press(0, 3'b100, {tag, "_b"});
    bus.SW = {4'($urandom), 4'(op)};
    press_op(r, c, z, v, tag);
    last_res = r;
  endtask

  task automatic run_op(input int a, input int b, input int op, input string tag);
    bus.SW = W'(a);
    press(0, 3'b010, {tag, "_a"});
    enter_op(a, b, op, tag);
  endtask

  task automatic chain(input int b, input int op, input string tag);
    bus.SW = W'($urandom);
    press(0, 3'b010, {tag, "_chain"});
    enter_op(last_res, b, op, tag);
  endtask

  task automatic clear(input string tag);
    press(1, 3'b001, tag);
    chk({tag, "_flags"}, {bus.CARRY_LED, bus.ZERO_LED, bus.OVF_LED}, 3'b000);
  endtask

  initial begin
    rst     = 1'b1;
    bus.BTN = 2'b00;
    bus.SW  = 8'h5A;
    #1;
    chk("rst_led", bus.LED, 8'h00);
    chk("rst_state", bus.STATE_LED, 3'b001);
    chk("rst_flags", {bus.CARRY_LED, bus.ZERO_LED, bus.OVF_LED}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_echo", bus.LED, 8'h5A);

    // Short bounces on ENTER must not advance the FSM
    for (int i = 0; i < 5; i++) begin
      bus.BTN[0] = 1'b1;
      repeat (2) @(negedge clk);
      bus.BTN[0] = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_state", bus.STATE_LED, 3'b001);

    // Clean hold: exact latency, single advance
    bus.SW     = 8'hF0;
    bus.BTN[0] = 1'b1;
    repeat (D + 3) @(posedge clk);
    @(negedge clk);
    chk("lat_before", bus.STATE_LED, 3'b001);
    @(negedge clk);
    chk("lat_at", bus.STATE_LED, 3'b010);
    repeat (10) @(negedge clk);
    chk("lat_once", bus.STATE_LED, 3'b010);
    release_btns();
    chk("lat_release", bus.STATE_LED, 3'b010);

    enter_op(8'hF0, 8'h20, 0, "add1");
    chk("add1_const", {bus.LED, bus.CARRY_LED, bus.ZERO_LED, bus.OVF_LED}, {8'h10, 3'b100});

    chain(8'h10, 4, "xor_chain");
    chk("xor_chain_const", {bus.LED, bus.ZERO_LED}, {8'h00, 1'b1});

    clear("clr1");
    run_op(8'h7F, 8'h01, 0, "add_ovf");
    chk("add_ovf_const", {bus.LED, bus.CARRY_LED, bus.OVF_LED}, {8'h80, 2'b01});

    clear("clr2");
    run_op(8'h05, 8'h07, 1, "sub");
    chk("sub_const", {bus.LED, bus.CARRY_LED}, {8'hFE, 1'b1});

    clear("clr3");
    run_op(8'h10, 8'h10, 14, "mul");
    chk("mul_const", {bus.LED, bus.CARRY_LED, bus.ZERO_LED}, {8'h00, 2'b11});

    // Into LOAD_B with flags still held, then ENTER and CLEAR together
    bus.SW = 8'h33;
    press(0, 3'b010, "to_load_b");
    chk("flags_held", bus.CARRY_LED, 1'b1);
    bus.SW  = 8'hC3;
    bus.BTN = 2'b11;
    repeat (D + 4) @(posedge clk);
    @(negedge clk);
    chk("both_state", bus.STATE_LED, 3'b001);
    chk("both_flags", {bus.CARRY_LED, bus.ZERO_LED, bus.OVF_LED}, 3'b000);
    chk("both_led", bus.LED, 8'hC3);
    release_btns();
    chk("both_after", bus.STATE_LED, 3'b001);

    // Every opcode with random operands, some results chained
    for (int i = 0; i < 16; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1)
        chain(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), $sformatf("rndc%0d", i));
      clear($sformatf("rclr%0d", i));
    end

    // Asynchronous reset while showing a result
    run_op(8'hF0, 8'h20, 0, "pre_rst");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_led", bus.LED, 8'h00);
    chk("mid_rst_state", bus.STATE_LED, 3'b001);
    chk("mid_rst_flags", {bus.CARRY_LED, bus.ZERO_LED, bus.OVF_LED}, 3'b000);
    @(negedge clk);
    rst    = 1'b0;
    bus.SW = 8'h3C;
    @(negedge clk);
    chk("mid_rst_echo", bus.LED, 8'h3C);
    chk("mid_rst_state2", bus.STATE_LED, 3'b001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
